// File: rtl/image_buffer_scanout_pkg.sv
// Shared constants and state types for the image buffer scan-out path
// and the upstream UART streaming controller that triggers it.
package image_buffer_scanout_pkg;

    localparam int BYTES_PER_PIXEL  = 2;
    // RGB565 pixels are stored big-endian: high byte at the even address.
    localparam int RGB565_HI_OFFSET = 0;
    localparam int RGB565_LO_OFFSET = 1;

    typedef enum logic [2:0] {
        SCAN_IDLE,
        SCAN_READ_HI,
        SCAN_READ_LO,
        SCAN_CAPTURE,
        SCAN_PRESENT,
        SCAN_DONE
    } scan_state_t;

    typedef enum logic [1:0] {
        STREAM_IDLE,
        STREAM_RECEIVE,
        STREAM_WRITE,
        STREAM_ENDED
    } stream_state_t;

    function automatic int image_buf_size(input int width, input int height);
        return width * height * BYTES_PER_PIXEL;
    endfunction

endpackage

// File: rtl/image_buffer_scanout_pixel_coord_counter.sv
// Raster-order pixel index plus x/y coordinate counters for the scan-out FSM.
module pixel_coord_counter #(
    parameter int NUM_PIXELS  = 1,
    parameter int IMAGE_BUF_X = 1,
    parameter int IMAGE_BUF_Y = 1,
    localparam int NW = $clog2(NUM_PIXELS) + 1,
    localparam int XW = $clog2(IMAGE_BUF_X) + 1,
    localparam int YW = $clog2(IMAGE_BUF_Y) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [NW-1:0] n,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n <= '0;
            x <= '0;
            y <= '0;
        end else if (clear) begin
            n <= '0;
            x <= '0;
            y <= '0;
        end else if (advance) begin
            n <= n + 1'b1;
            // y never wraps: the final pixel ends the frame instead of advancing
            if (x == XW'(IMAGE_BUF_X - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (n == NW'(NUM_PIXELS - 1));

endmodule

// File: rtl/image_buffer_scanout.sv
// Reads the RGB565 frame back from byte-wide memory after streaming ends and
// presents it pixel by pixel, with x/y tags, over a valid/ready handshake.
module image_buffer_scanout
    import image_buffer_scanout_pkg::*;
#(
    parameter int IMAGE_BUF_X = 1,
    parameter int IMAGE_BUF_Y = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_out,
    output logic [15:0] pix_data,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int IMAGE_BUF_SIZE = image_buf_size(IMAGE_BUF_X, IMAGE_BUF_Y);
    localparam int NUM_PIXELS     = IMAGE_BUF_SIZE / BYTES_PER_PIXEL;
    localparam int NW             = $clog2(NUM_PIXELS) + 1;
    localparam int XW             = $clog2(IMAGE_BUF_X) + 1;
    localparam int YW             = $clog2(IMAGE_BUF_Y) + 1;

    scan_state_t   r_state;
    scan_state_t   w_stateNext;
    logic [NW-1:0] w_n;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_last;
    logic          w_clear;
    logic          w_advance;
    logic [31:0]   w_pixBase;

    pixel_coord_counter #(
        .NUM_PIXELS (NUM_PIXELS),
        .IMAGE_BUF_X(IMAGE_BUF_X),
        .IMAGE_BUF_Y(IMAGE_BUF_Y)
    ) u_coord (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .advance(w_advance),
        .n      (w_n),
        .x      (w_x),
        .y      (w_y),
        .last   (w_last)
    );

    assign w_pixBase = 32'(w_n) * 32'(BYTES_PER_PIXEL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SCAN_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            SCAN_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_stateNext = SCAN_READ_HI;
                end
            end
            SCAN_READ_HI: begin
                mem_rd      = 1'b1;
                mem_addr    = w_pixBase + 32'(RGB565_HI_OFFSET);
                w_stateNext = SCAN_READ_LO;
            end
            SCAN_READ_LO: begin
                mem_rd      = 1'b1;
                mem_addr    = w_pixBase + 32'(RGB565_LO_OFFSET);
                w_stateNext = SCAN_CAPTURE;
            end
            SCAN_CAPTURE: begin
                w_stateNext = SCAN_PRESENT;
            end
            SCAN_PRESENT: begin
                if (pix_ready) begin
                    if (w_last) begin
                        w_stateNext = SCAN_DONE;
                    end else begin
                        w_advance   = 1'b1;
                        w_stateNext = SCAN_READ_HI;
                    end
                end
            end
            SCAN_DONE: begin
                w_stateNext = SCAN_IDLE;
            end
            default: begin
                w_stateNext = SCAN_IDLE;
            end
        endcase
    end

    // Memory data lags the read strobe by one cycle, so each byte lands one state late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_data <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
        end else if (r_state == SCAN_READ_LO) begin
            pix_data[15:8] <= mem_out;
        end else if (r_state == SCAN_CAPTURE) begin
            pix_data[7:0] <= mem_out;
            pix_x         <= 16'(w_x);
            pix_y         <= 16'(w_y);
        end
    end

    assign pix_valid  = (r_state == SCAN_PRESENT);
    assign busy       = (r_state != SCAN_IDLE);
    assign frame_done = (r_state == SCAN_DONE);

endmodule

// File: tb/tb_image_buffer_scanout.sv
// Self-checking bench for image_buffer_scanout: three instances (2x2, 1x1, 3x2)
// checked every cycle against a frame-level model, plus literal spot checks.
module tb_image_buffer_scanout;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic [2:0]       start = '0;
    logic [2:0]       memRd;
    logic [2:0][31:0] memAddr;
    logic [2:0][7:0]  memOut = '0;
    logic [2:0][15:0] pixData;
    logic [2:0][15:0] pixX;
    logic [2:0][15:0] pixY;
    logic [2:0]       pixValid;
    logic [2:0]       pixReady = 3'b111;
    logic [2:0]       busy;
    logic [2:0]       frameDone;

    logic [7:0]  mem [3][16];

    int compared = 0;
    int mismatched = 0;
    int cycleNo = 0;

    bit          inFrame [3];
    bit          doneNow [3];
    bit          prevValid [3];
    int          waitC [3];
    int          pixIdx [3];
    int          readAddr [3];
    int          doneCount [3];
    int          startCycle [3];
    int          maxAddr [3];
    logic [47:0] cap [3][8];
    int          capCnt [3];
    int          rise [3][8];
    int          riseCnt [3];
    int          addrLog [3][16];
    int          addrCnt [3];

    always #5 clk = ~clk;

    image_buffer_scanout #(.IMAGE_BUF_X(2), .IMAGE_BUF_Y(2)) dut0 (
        .clk(clk), .reset(rstN), .start(start[0]), .mem_rd(memRd[0]), .mem_addr(memAddr[0]),
        .mem_out(memOut[0]), .pix_data(pixData[0]), .pix_x(pixX[0]), .pix_y(pixY[0]),
        .pix_valid(pixValid[0]), .pix_ready(pixReady[0]), .busy(busy[0]), .frame_done(frameDone[0]));

    image_buffer_scanout #(.IMAGE_BUF_X(1), .IMAGE_BUF_Y(1)) dut1 (
        .clk(clk), .reset(rstN), .start(start[1]), .mem_rd(memRd[1]), .mem_addr(memAddr[1]),
        .mem_out(memOut[1]), .pix_data(pixData[1]), .pix_x(pixX[1]), .pix_y(pixY[1]),
        .pix_valid(pixValid[1]), .pix_ready(pixReady[1]), .busy(busy[1]), .frame_done(frameDone[1]));

    image_buffer_scanout #(.IMAGE_BUF_X(3), .IMAGE_BUF_Y(2)) dut2 (
        .clk(clk), .reset(rstN), .start(start[2]), .mem_rd(memRd[2]), .mem_addr(memAddr[2]),
        .mem_out(memOut[2]), .pix_data(pixData[2]), .pix_x(pixX[2]), .pix_y(pixY[2]),
        .pix_valid(pixValid[2]), .pix_ready(pixReady[2]), .busy(busy[2]), .frame_done(frameDone[2]));

    function automatic int nx(input int k);
        case (k)
            0: return 2;
            1: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int ny(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cycleNo, act, exp);
        end
    endtask

    // Byte-wide memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (memRd[k]) memOut[k] <= mem[k][memAddr[k][3:0]];
        end
    end

    // Frame-level model: start opens a frame, each pixel needs three fetch cycles
    // before it is shown, the last accept is followed by a single done cycle.
    always @(negedge clk) begin
        cycleNo++;
        for (int k = 0; k < 3; k++) begin
            bit expValid;
            int pi;
            if (!rstN) begin
                checkOutput("resetFlags", 64'({memRd[k], busy[k], frameDone[k], pixValid[k]}), 64'd0);
                checkOutput("resetData", {memAddr[k], pixData[k], pixX[k]}, 64'd0);
                checkOutput("resetPixY", 64'(pixY[k]), 64'd0);
                inFrame[k] = 1'b0;
                doneNow[k] = 1'b0;
                prevValid[k] = 1'b0;
                waitC[k] = 0;
            end else begin
                expValid = inFrame[k] && !doneNow[k] && (waitC[k] == 0);
                checkOutput("pixValid", 64'(pixValid[k]), 64'(expValid));
                checkOutput("busy", 64'(busy[k]), 64'(inFrame[k]));
                checkOutput("frameDone", 64'(frameDone[k]), 64'(doneNow[k]));
                if (frameDone[k]) doneCount[k]++;
                if (memRd[k]) begin
                    checkOutput("memRead", {31'd0, inFrame[k], memAddr[k]}, {31'd0, 1'b1, 32'(readAddr[k])});
                    if (addrCnt[k] < 16) addrLog[k][addrCnt[k]] = int'(memAddr[k]);
                    addrCnt[k]++;
                    if (int'(memAddr[k]) > maxAddr[k]) maxAddr[k] = int'(memAddr[k]);
                    readAddr[k]++;
                end
                if (expValid) begin
                    pi = pixIdx[k];
                    checkOutput("pixel", 64'({pixData[k], pixX[k], pixY[k]}),
                                64'({mem[k][2*pi], mem[k][2*pi+1], 16'(pi % nx(k)), 16'(pi / nx(k))}));
                end
                if (pixValid[k] && !prevValid[k]) begin
                    if (riseCnt[k] < 8) rise[k][riseCnt[k]] = cycleNo;
                    riseCnt[k]++;
                end
                prevValid[k] = pixValid[k];
                if (pixValid[k] && pixReady[k]) begin
                    if (capCnt[k] < 8) cap[k][capCnt[k]] = {pixData[k], pixX[k], pixY[k]};
                    capCnt[k]++;
                end
                if (doneNow[k]) begin
                    doneNow[k] = 1'b0;
                    inFrame[k] = 1'b0;
                end else if (!inFrame[k]) begin
                    if (start[k]) begin
                        inFrame[k] = 1'b1;
                        waitC[k] = 3;
                        pixIdx[k] = 0;
                        readAddr[k] = 0;
                        capCnt[k] = 0;
                        riseCnt[k] = 0;
                        addrCnt[k] = 0;
                        maxAddr[k] = 0;
                        startCycle[k] = cycleNo;
                    end
                end else if (waitC[k] > 0) begin
                    waitC[k]--;
                end else if (pixReady[k]) begin
                    if (pixIdx[k] == nx(k) * ny(k) - 1) doneNow[k] = 1'b1;
                    else begin
                        pixIdx[k]++;
                        waitC[k] = 3;
                    end
                end
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k);
        waitCycle();
        start[k] = 1'b1;
        waitCycle();
        start[k] = 1'b0;
    endtask

    task automatic waitDone(input int k);
        int n = 0;
        while (!frameDone[k] && n < 200) begin
            waitCycle();
            n++;
        end
        checkOutput("frameDoneSeen", 64'(frameDone[k]), 64'd1);
    endtask

    task automatic waitAccepts(input int k, input int cnt, input bit needValid);
        int n = 0;
        while (!(capCnt[k] >= cnt && (!needValid || pixValid[k])) && n < 200) begin
            waitCycle();
            n++;
        end
        checkOutput("acceptWait", 64'(capCnt[k] >= cnt), 64'd1);
    endtask

    initial begin
        logic [7:0]  img0 [8];
        logic [47:0] exp0 [4];
        int          expX [6];
        int          expY [6];
        int          doneBefore;
        img0 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        exp0 = '{{16'h1234, 16'd0, 16'd0}, {16'h5678, 16'd1, 16'd0},
                 {16'h9ABC, 16'd0, 16'd1}, {16'hDEF0, 16'd1, 16'd1}};
        expX = '{0, 1, 2, 0, 1, 2};
        expY = '{0, 0, 0, 1, 1, 1};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) mem[k][i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[0][i] = img0[i];
        mem[1][0] = 8'hF8;
        mem[1][1] = 8'h00;
        for (int i = 0; i < 12; i++) mem[2][i] = 8'(8'h21 + i * 13);

        repeat (3) waitCycle();
        checkOutput("resetPixData", 64'(pixData[0]), 64'd0);
        checkOutput("resetBusy", 64'(busy[0]), 64'd0);
        rstN = 1'b1;
        repeat (2) waitCycle();

        $display("[TB] 2x2 frame, ready high");
        applyStimulus(0);
        waitDone(0);
        checkOutput("frame1Count", 64'(capCnt[0]), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("frame1Pixel", 64'(cap[0][i]), 64'(exp0[i]));
        waitCycle();
        checkOutput("frame1BusyLow", 64'(busy[0]), 64'd0);

        $display("[TB] 2x2 frame, 5-cycle stall on pixel 1");
        applyStimulus(0);
        waitAccepts(0, 1, 1'b0);
        pixReady[0] = 1'b0;
        waitAccepts(0, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallHold", 64'({pixValid[0], pixData[0], pixX[0]}), 64'({1'b1, 16'h5678, 16'd1}));
            waitCycle();
        end
        pixReady[0] = 1'b1;
        waitDone(0);
        checkOutput("stallReads", 64'(addrCnt[0]), 64'd8);
        checkOutput("stallCount", 64'(capCnt[0]), 64'd4);

        $display("[TB] 2x2 frame, start repeated mid-frame and in done cycle");
        waitCycle();
        doneBefore = doneCount[0];
        applyStimulus(0);
        repeat (4) waitCycle();
        start[0] = 1'b1;
        waitCycle();
        start[0] = 1'b0;
        waitDone(0);
        start[0] = 1'b1;
        waitCycle();
        start[0] = 1'b0;
        checkOutput("doneStartIgnored", 64'(busy[0]), 64'd0);
        repeat (3) waitCycle();
        checkOutput("restartCount", 64'(capCnt[0]), 64'd4);
        checkOutput("restartDones", 64'(doneCount[0] - doneBefore), 64'd1);

        $display("[TB] reset during third pixel");
        applyStimulus(0);
        waitAccepts(0, 2, 1'b1);
        doneBefore = doneCount[0];
        rstN = 1'b0;
        #1;
        checkOutput("asyncResetFlags", 64'({pixValid[0], busy[0], memRd[0], frameDone[0]}), 64'd0);
        checkOutput("asyncResetData", {memAddr[0], pixData[0], pixX[0]}, 64'd0);
        checkOutput("asyncResetPixY", 64'(pixY[0]), 64'd0);
        repeat (2) waitCycle();
        rstN = 1'b1;
        repeat (10) waitCycle();
        checkOutput("abortNoDone", 64'(doneCount[0] - doneBefore), 64'd0);
        applyStimulus(0);
        waitAccepts(0, 1, 1'b0);
        checkOutput("freshFirstPixel", 64'(cap[0][0]), 64'(exp0[0]));
        waitDone(0);

        $display("[TB] 1x1 frame");
        applyStimulus(1);
        waitDone(1);
        checkOutput("oneCount", 64'(capCnt[1]), 64'd1);
        checkOutput("onePixel", 64'(cap[1][0]), 64'({16'hF800, 16'd0, 16'd0}));
        checkOutput("oneLatency", 64'(rise[1][0] - startCycle[1] - 1), 64'd3);
        checkOutput("oneAddrCount", 64'(addrCnt[1]), 64'd2);
        checkOutput("oneAddr0", 64'(addrLog[1][0]), 64'd0);
        checkOutput("oneAddr1", 64'(addrLog[1][1]), 64'd1);

        $display("[TB] 3x2 frame");
        applyStimulus(2);
        waitDone(2);
        checkOutput("wideCount", 64'(capCnt[2]), 64'd6);
        for (int i = 0; i < 6; i++)
            checkOutput("wideCoord", 64'(cap[2][i][31:0]), 64'({16'(expX[i]), 16'(expY[i])}));
        checkOutput("wideMaxAddr", 64'(maxAddr[2]), 64'd11);
        for (int i = 1; i < 6; i++)
            checkOutput("wideSpacing", 64'(rise[2][i] - rise[2][i-1]), 64'd4);
        repeat (3) waitCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
